// File: rtl/fetch_loader_ctrl_pkg.sv
// Shared definitions for the instruction loader / pipeline sequencer.
// State encoding, UART command bytes and the default program-end word.
package fetch_loader_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StStep
  } state_e;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;

  localparam int unsigned BYTES_PER_WORD = 4;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_loader_ctrl_byte_word_assembler.sv
// Collects four bytes MSB first into a 32-bit word; o_done flags the cycle
// the fourth byte arrives, with o_word already holding the complete word.
module fetch_loader_ctrl_byte_word_assembler
  import fetch_loader_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic [31:0] o_word,
  output logic        o_done
);

  logic [23:0] r_shift;
  logic [1:0]  r_count;

  assign o_done = i_valid && (r_count == 2'(BYTES_PER_WORD - 1));
  assign o_word = {r_shift, i_data};

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (i_valid) begin
      r_shift <= {r_shift[15:0], i_data};
      r_count <= r_count + 2'd1;
    end
  end

endmodule

// File: rtl/fetch_loader_ctrl.sv
// Loads instruction memory from UART bytes, then gates the pipeline in
// continuous-run or single-step mode until the halt instruction retires.
module fetch_loader_ctrl
  import fetch_loader_ctrl_pkg::*;
#(
  parameter int unsigned       NBITS     = 32,
  parameter int unsigned       MEM_DEPTH = 64,
  parameter logic [NBITS-1:0]  HALT_WORD = NBITS'(HALT_WORD_DEFAULT)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  input  logic             i_halt,
  output logic             o_inst_mem_wr_en,
  output logic [NBITS-1:0] o_inst_mem_addr,
  output logic [NBITS-1:0] o_inst_mem_data,
  output logic             o_pipe_en,
  output logic             o_pipe_rst,
  output logic             o_loaded,
  output logic             o_halted,
  output logic             o_load_err
);

  localparam int unsigned CW = $clog2(MEM_DEPTH + 1);

  state_e           r_state;
  logic             r_wr_en;
  logic [NBITS-1:0] r_addr;
  logic [NBITS-1:0] r_data;
  logic             r_pipe_en;
  logic             r_pipe_rst;
  logic             r_loaded;
  logic             r_halted;
  logic             r_load_err;
  logic [CW-1:0]    r_words;

  logic             w_clear;
  logic             w_asm_valid;
  logic [31:0]      w_word;
  logic [NBITS-1:0] w_word_n;
  logic             w_done;
  logic             w_can_run;

  assign w_clear     = (r_state == StIdle) && i_rx_valid && (i_rx_data == CMD_LOAD);
  assign w_asm_valid = (r_state == StLoad) && i_rx_valid;
  assign w_word_n    = NBITS'(w_word);
  assign w_can_run   = r_loaded && !r_halted;

  fetch_loader_ctrl_byte_word_assembler u_asm (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (w_clear),
    .i_valid (w_asm_valid),
    .i_data  (i_rx_data),
    .o_word  (w_word),
    .o_done  (w_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_wr_en    <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_pipe_en  <= 1'b0;
      r_pipe_rst <= 1'b0;
      r_loaded   <= 1'b0;
      r_halted   <= 1'b0;
      r_load_err <= 1'b0;
      r_words    <= '0;
    end else begin
      r_wr_en <= 1'b0;
      // Address advances after the cycle its write strobe was presented.
      if (r_wr_en) r_addr <= r_addr + NBITS'(4);
      unique case (r_state)
        StIdle: begin
          if (i_rx_valid) begin
            if (i_rx_data == CMD_LOAD) begin
              r_state    <= StLoad;
              r_loaded   <= 1'b0;
              r_halted   <= 1'b0;
              r_load_err <= 1'b0;
              r_addr     <= '0;
              r_words    <= '0;
              r_pipe_rst <= 1'b1;
            end else if (i_rx_data == CMD_RUN && w_can_run) begin
              r_state   <= StRun;
              r_pipe_en <= 1'b1;
            end else if (i_rx_data == CMD_STEP && w_can_run) begin
              r_state   <= StStep;
              r_pipe_en <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (w_done) begin
            if (r_words == CW'(MEM_DEPTH)) begin
              r_load_err <= 1'b1;
              r_pipe_rst <= 1'b0;
              r_state    <= StIdle;
            end else begin
              r_wr_en <= 1'b1;
              r_data  <= w_word_n;
              r_words <= r_words + CW'(1);
              if (w_word_n == HALT_WORD) begin
                r_loaded   <= 1'b1;
                r_pipe_rst <= 1'b0;
                r_state    <= StIdle;
              end
            end
          end
        end
        StRun: begin
          if (i_halt) begin
            r_pipe_en <= 1'b0;
            r_halted  <= 1'b1;
            r_state   <= StIdle;
          end
        end
        StStep: begin
          r_pipe_en <= 1'b0;
          r_state   <= StIdle;
          if (i_halt) r_halted <= 1'b1;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_inst_mem_wr_en = r_wr_en;
  assign o_inst_mem_addr  = r_addr;
  assign o_inst_mem_data  = r_data;
  assign o_pipe_en        = r_pipe_en;
  assign o_pipe_rst       = r_pipe_rst;
  assign o_loaded         = r_loaded;
  assign o_halted         = r_halted;
  assign o_load_err       = r_load_err;

endmodule

// File: tb/tb_fetch_loader_ctrl.sv
// Scenario bench for fetch_loader_ctrl: expected memory writes are queued as
// bytes are sent and compared when the write strobe appears.
module tb_fetch_loader_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        halt;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] data;
  logic        pipe_en;
  logic        pipe_rst;
  logic        loaded;
  logic        halted;
  logic        load_err;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int pe_cnt = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_loader_ctrl #(
    .NBITS     (32),
    .MEM_DEPTH (4),
    .HALT_WORD (32'hFFFF_FFFF)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_rx_data        (rx_data),
    .i_rx_valid       (rx_valid),
    .i_halt           (halt),
    .o_inst_mem_wr_en (wr_en),
    .o_inst_mem_addr  (addr),
    .o_inst_mem_data  (data),
    .o_pipe_en        (pipe_en),
    .o_pipe_rst       (pipe_rst),
    .o_loaded         (loaded),
    .o_halted         (halted),
    .o_load_err       (load_err)
  );

  // Advance one cycle; outputs are sampled on the falling edge.
  task automatic tick();
    logic [63:0] e;
    @(negedge clk);
    if (wr_en) begin
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr=%h data=%h, expected no write", addr, data);
      end else begin
        e = exp_q.pop_front();
        if ({addr, data} !== e) begin
          errors++;
          $display("FAIL wr_data: got addr=%h data=%h, expected addr=%h data=%h",
                   addr, data, e[63:32], e[31:0]);
        end
      end
    end
    if (pipe_en) pe_cnt++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] a, input bit expect_wr);
    if (expect_wr) exp_q.push_back({a, w});
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    halt     = 1'b0;
    do_reset();
    checks++;
    if ({wr_en, pipe_en, pipe_rst, loaded, halted, load_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 000000",
               {wr_en, pipe_en, pipe_rst, loaded, halted, load_err});
    end
    checks++;
    if ({addr, data} !== 64'h0) begin
      errors++;
      $display("FAIL reset_bus: got addr=%h data=%h, expected 0/0", addr, data);
    end
  endtask

  task automatic test_load();
    int rst_low = 0;
    int w0 = wr_cnt;
    send_byte(8'h4C);
    checks++;
    if (pipe_rst !== 1'b1 || pipe_en !== 1'b0) begin
      errors++;
      $display("FAIL load_enter: got pipe_rst=%b pipe_en=%b, expected 1/0", pipe_rst, pipe_en);
    end
    exp_q.push_back({32'h0, 32'h1234_5678});
    foreach (data[i]) begin end
    send_byte(8'h12); if (!pipe_rst) rst_low++; tick(); if (!pipe_rst) rst_low++;
    send_byte(8'h34); if (!pipe_rst) rst_low++; tick(); if (!pipe_rst) rst_low++;
    send_byte(8'h56); if (!pipe_rst) rst_low++; tick(); if (!pipe_rst) rst_low++;
    send_byte(8'h78); if (!pipe_rst) rst_low++; tick(); if (!pipe_rst) rst_low++;
    send_word(32'hFFFF_FFFF, 32'h4, 1'b1);
    checks++;
    if (rst_low != 0) begin
      errors++;
      $display("FAIL load_pipe_rst: got %0d low cycles during load, expected 0", rst_low);
    end
    checks++;
    if (loaded !== 1'b1 || pipe_rst !== 1'b0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL load_done: got loaded=%b pipe_rst=%b err=%b, expected 1/0/0",
               loaded, pipe_rst, load_err);
    end
    tick();
    checks++;
    if (wr_cnt - w0 != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL load_writes: got %0d writes (%0d pending), expected 2 (0)",
               wr_cnt - w0, exp_q.size());
    end
  endtask

  task automatic test_run();
    int pe = 0;
    send_byte(8'h43);
    if (pipe_en) pe = 1;
    for (int i = 0; i < 40 && pe > 0; i++) begin
      halt = (pe == 10);
      tick();
      if (pipe_en) pe++;
      else break;
    end
    halt = 1'b0;
    checks++;
    if (pe != 10) begin
      errors++;
      $display("FAIL run_len: got pipe_en high %0d cycles, expected 10", pe);
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL run_halted: got %b, expected 1", halted);
    end
    pe_cnt = 0;
    send_byte(8'h43);
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (pe_cnt != 0) begin
      errors++;
      $display("FAIL run_after_halt: got %0d enable cycles, expected 0", pe_cnt);
    end
  endtask

  task automatic test_step();
    int pulses = 0;
    do_reset();
    pe_cnt = 0;
    send_byte(8'h53);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (pe_cnt != 0) begin
      errors++;
      $display("FAIL step_unloaded: got %0d enable cycles, expected 0", pe_cnt);
    end
    send_byte(8'h4C);
    send_word(32'hFFFF_FFFF, 32'h0, 1'b1);
    tick();
    pe_cnt = 0;
    for (int s = 0; s < 3; s++) begin
      send_byte(8'h53);
      if (pipe_en) begin
        tick();
        if (!pipe_en) pulses++;
      end
      tick();
    end
    checks++;
    if (pulses != 3 || pe_cnt != 3) begin
      errors++;
      $display("FAIL step_pulses: got %0d single pulses over %0d cycles, expected 3/3",
               pulses, pe_cnt);
    end
    send_byte(8'h53);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    checks++;
    if (halted !== 1'b1 || pipe_en !== 1'b0) begin
      errors++;
      $display("FAIL step_halt: got halted=%b pipe_en=%b, expected 1/0", halted, pipe_en);
    end
  endtask

  task automatic test_overflow();
    int w0;
    do_reset();
    w0 = wr_cnt;
    send_byte(8'h4C);
    for (int i = 0; i < 5; i++)
      send_word(32'hA000_0000 + i, 32'(i * 4), i < 4);
    checks++;
    if (load_err !== 1'b1 || loaded !== 1'b0 || pipe_rst !== 1'b0) begin
      errors++;
      $display("FAIL ovf_flags: got err=%b loaded=%b pipe_rst=%b, expected 1/0/0",
               load_err, loaded, pipe_rst);
    end
    tick();
    tick();
    checks++;
    if (wr_cnt - w0 != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ovf_writes: got %0d writes (%0d pending), expected 4 (0)",
               wr_cnt - w0, exp_q.size());
    end
  endtask

  task automatic test_reset_midload();
    send_byte(8'h4C);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (pipe_rst !== 1'b0 || addr !== 32'h0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL midload_rst: got pipe_rst=%b addr=%h err=%b, expected 0/0/0",
               pipe_rst, addr, load_err);
    end
    send_byte(8'h4C);
    send_word(32'h1122_3344, 32'h0, 1'b1);
    send_word(32'hFFFF_FFFF, 32'h4, 1'b1);
    tick();
    checks++;
    if (loaded !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midload_reload: got loaded=%b pending=%0d, expected 1/0",
               loaded, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_run();
    test_step();
    test_overflow();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
